// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the regfile_ctrl instruction sequencer.
// Instruction layout: op[7:6], rs[5:4], rt[3:2], rd[1:0]; imm aliases rd.
package regfile_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int INSTR_W = 8;
  localparam int OP_W    = 2;
  localparam int IMM_W   = 2;

  localparam int OP_LSB  = 6;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 2;
  localparam int RD_LSB  = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDI = 2'b01,
    OP_SUB  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Instruction handshake plus register-file port bundle for regfile_ctrl.
// slave = the controller, master = instruction source / register file side.
interface regfile_ctrl_if;
  import regfile_ctrl_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  rf_read_reg1;
  logic [ADDR_W-1:0]  rf_read_reg2;
  logic [DATA_W-1:0]  rf_read_data1;
  logic [DATA_W-1:0]  rf_read_data2;
  logic [ADDR_W-1:0]  rf_write_reg;
  logic [DATA_W-1:0]  rf_write_data;
  logic               rf_reg_write;
  logic               done;
  logic               ovf;

  modport slave (
    input  instr_valid, instr, rf_read_data1, rf_read_data2,
    output instr_ready, rf_read_reg1, rf_read_reg2, rf_write_reg,
           rf_write_data, rf_reg_write, done, ovf
  );

  modport master (
    output instr_valid, instr, rf_read_data1, rf_read_data2,
    input  instr_ready, rf_read_reg1, rf_read_reg2, rf_write_reg,
           rf_write_data, rf_reg_write, done, ovf
  );

endinterface

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU for regfile_ctrl: ADD / ADDI / SUB modulo 2^DATA_W.
// Signed-overflow detection exists only when REGFILE_CTRL_OVF_EN is defined.
module regfile_ctrl_alu
  import regfile_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm_ext,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  // Result select; carry and borrow fall off the top bit.
  always_comb begin
    result = {DATA_W{1'b0}};
    case (op)
      OP_ADD:  result = op_a + op_b;
      OP_ADDI: result = op_a + imm_ext;
      OP_SUB:  result = op_a - op_b;
      OP_NOP:  result = {DATA_W{1'b0}};
      default: result = {DATA_W{1'b0}};
    endcase
  end

`ifdef REGFILE_CTRL_OVF_EN
  // Two's-complement overflow: operand signs vs. result sign.
  always_comb begin
    ovf = 1'b0;
    case (op)
      OP_ADD:  ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
      OP_ADDI: ovf = (op_a[DATA_W-1] == imm_ext[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
      OP_SUB:  ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
      OP_NOP:  ovf = 1'b0;
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: IDLE/READ/EXEC/WB sequencer, one instruction per 4 cycles.
// Define REGFILE_CTRL_OVF_EN to enable the sticky signed-overflow flag on ovf.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  regfile_ctrl_if.slave bus
);

  state_e             state_r;
  state_e             state_s;
  logic [INSTR_W-1:0] ir_r;
  logic [DATA_W-1:0]  opa_r;
  logic [DATA_W-1:0]  opb_r;
  logic [DATA_W-1:0]  res_r;
  logic [DATA_W-1:0]  alu_res_s;
  logic [DATA_W-1:0]  imm_ext_s;
  logic               alu_ovf_s;
  logic               ready_r;
  logic               handshake_s;
  op_e                op_s;

  assign op_s        = op_e'(ir_r[OP_LSB +: OP_W]);
  assign imm_ext_s   = sext_imm(ir_r[IMM_LSB +: IMM_W]);
  assign handshake_s = bus.instr_valid && ready_r;

  regfile_ctrl_alu u_alu (
    .op_a    (opa_r),
    .op_b    (opb_r),
    .imm_ext (imm_ext_s),
    .op      (op_s),
    .result  (alu_res_s),
    .ovf     (alu_ovf_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) state_s = ST_READ;
        else             state_s = ST_IDLE;
      end
      ST_READ: state_s = ST_EXEC;
      ST_EXEC: state_s = ST_WB;
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_IDLE);
    end
  end

  // Instruction capture and operand/result pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r  <= {INSTR_W{1'b0}};
      opa_r <= {DATA_W{1'b0}};
      opb_r <= {DATA_W{1'b0}};
      res_r <= {DATA_W{1'b0}};
    end else begin
      if (handshake_s)          ir_r  <= bus.instr;
      if (state_r == ST_READ) begin
        opa_r <= bus.rf_read_data1;
        opb_r <= bus.rf_read_data2;
      end
      if (state_r == ST_EXEC)   res_r <= alu_res_s;
    end
  end

`ifdef REGFILE_CTRL_OVF_EN
  logic ovf_pend_r;
  logic ovf_r;

  // Overflow is computed in EXEC and published on the WB edge; NOP leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      if (state_r == ST_EXEC) ovf_pend_r <= alu_ovf_s;
      if ((state_r == ST_WB) && (op_s != OP_NOP)) ovf_r <= ovf_pend_r;
    end
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = alu_ovf_s;
`endif

  assign bus.instr_ready   = ready_r;
  assign bus.rf_read_reg1  = ir_r[RS_LSB +: ADDR_W];
  assign bus.rf_read_reg2  = ir_r[RT_LSB +: ADDR_W];
  assign bus.rf_write_reg  = (op_s == OP_ADDI) ? ir_r[RT_LSB +: ADDR_W] : ir_r[RD_LSB +: ADDR_W];
  assign bus.rf_write_data = res_r;
  assign bus.rf_reg_write  = (state_r == ST_WB) && (op_s != OP_NOP);
  assign bus.done          = (state_r == ST_WB);

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl with a 4x8 register-file model.
// Expected ovf follows REGFILE_CTRL_OVF_EN.
module tb_regfile_ctrl;
  import regfile_ctrl_pkg::*;

`ifdef REGFILE_CTRL_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  regfile_ctrl_if bus ();

  regfile_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] rf [0:3];
  logic       load_en;
  logic [1:0] load_addr;
  logic [7:0] load_data;

  assign bus.rf_read_data1 = rf[bus.rf_read_reg1];
  assign bus.rf_read_data2 = rf[bus.rf_read_reg2];

  // Register file model: bench preload port has priority over DUT writes.
  always @(posedge clk) begin
    if (load_en) rf[load_addr] <= load_data;
    else if (bus.rf_reg_write) rf[bus.rf_write_reg] <= bus.rf_write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // Issue one instruction from IDLE; capture the WB-cycle outputs and ovf after the WB edge.
  task automatic run_instr(input logic [7:0] ins, output logic wen, output logic [1:0] wreg,
                           output logic [7:0] wdata, output logic dn, output logic ov);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = ins;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    wen = bus.rf_reg_write; wreg = bus.rf_write_reg; wdata = bus.rf_write_data; dn = bus.done;
    @(posedge clk);
    #1 ov = bus.ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) preload(i[1:0], 8'h00);
    @(negedge clk);
    n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.instr_ready); end
    n_checks++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", bus.rf_reg_write); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_checks++; if (bus.rf_write_data !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", bus.rf_write_data); end
    n_checks++; if ({bus.rf_read_reg1, bus.rf_read_reg2, bus.rf_write_reg} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_addr: got %b want 000000", {bus.rf_read_reg1, bus.rf_read_reg2, bus.rf_write_reg}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.instr_ready); end
  endtask

  task automatic test_arith();
    logic wen, dn, ov; logic [1:0] wreg; logic [7:0] wdata;
    run_instr(8'h47, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, dn, wreg, wdata} !== {1'b1, 1'b1, 2'd1, 8'hFF}) begin
      n_fail++; $display("FAIL addi_neg1: got wen=%b done=%b reg=%0d data=%h want 1 1 1 ff", wen, dn, wreg, wdata); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL addi_neg1_ovf: got %b want 0", ov); end
    run_instr(8'h16, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, dn, wreg, wdata} !== {1'b1, 1'b1, 2'd2, 8'hFE}) begin
      n_fail++; $display("FAIL add_r1r1: got wen=%b done=%b reg=%0d data=%h want 1 1 2 fe", wen, dn, wreg, wdata); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL add_r1r1_ovf: got %b want 0", ov); end
    run_instr(8'h87, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, dn, wreg, wdata} !== {1'b1, 1'b1, 2'd3, 8'h01}) begin
      n_fail++; $display("FAIL sub_r0r1: got wen=%b done=%b reg=%0d data=%h want 1 1 3 01", wen, dn, wreg, wdata); end
    n_checks++; if ({rf[1], rf[2], rf[3]} !== {8'hFF, 8'hFE, 8'h01}) begin
      n_fail++; $display("FAIL rf_contents: got %h %h %h want ff fe 01", rf[1], rf[2], rf[3]); end
  endtask

  task automatic test_ovf();
    logic wen, dn, ov; logic [1:0] wreg; logic [7:0] wdata;
    preload(2'd1, 8'h7F);
    preload(2'd2, 8'h01);
    run_instr(8'h1B, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, wreg, wdata} !== {1'b1, 2'd3, 8'h80}) begin
      n_fail++; $display("FAIL add_ovf_data: got wen=%b reg=%0d data=%h want 1 3 80", wen, wreg, wdata); end
    n_checks++; if (ov !== EXP_OVF) begin n_fail++; $display("FAIL add_ovf_flag: got %b want %b", ov, EXP_OVF); end
    run_instr(8'hC0, wen, wreg, wdata, dn, ov);
    n_checks++; if ({dn, wen} !== 2'b10) begin n_fail++; $display("FAIL nop: got done=%b wen=%b want 1 0", dn, wen); end
    n_checks++; if (ov !== EXP_OVF) begin n_fail++; $display("FAIL nop_ovf_hold: got %b want %b", ov, EXP_OVF); end
    run_instr(8'h46, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, wreg, wdata, ov} !== {1'b1, 2'd1, 8'hFE, 1'b0}) begin
      n_fail++; $display("FAIL addi_neg2: got wen=%b reg=%0d data=%h ovf=%b want 1 1 fe 0", wen, wreg, wdata, ov); end
    preload(2'd1, 8'h7F);
    run_instr(8'h55, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, wreg, wdata, ov} !== {1'b1, 2'd1, 8'h80, EXP_OVF}) begin
      n_fail++; $display("FAIL addi_pos1_ovf: got wen=%b reg=%0d data=%h ovf=%b want 1 1 80 %b", wen, wreg, wdata, ov, EXP_OVF); end
    run_instr(8'hB9, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, wreg, wdata, ov} !== {1'b1, 2'd1, 8'h7F, EXP_OVF}) begin
      n_fail++; $display("FAIL sub_ovf: got wen=%b reg=%0d data=%h ovf=%b want 1 1 7f %b", wen, wreg, wdata, ov, EXP_OVF); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = 8'h47;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++; if (bus.instr_ready !== ((i % 4) == 0)) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, bus.instr_ready, ((i % 4) == 0)); end
      n_checks++; if (bus.done !== ((i % 4) == 3)) begin
        n_fail++; $display("FAIL b2b_done[%0d]: got %b want %b", i, bus.done, ((i % 4) == 3)); end
      if (bus.instr_ready && bus.instr_valid) accepts++;
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    n_checks++; if (accepts !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", accepts); end
  endtask

  task automatic test_instr_change();
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = 8'h47;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0; bus.instr = 8'h16;
    n_checks++; if ({bus.rf_read_reg1, bus.rf_read_reg2} !== {2'd0, 2'd1}) begin
      n_fail++; $display("FAIL chg_read_addr: got %0d %0d want 0 1", bus.rf_read_reg1, bus.rf_read_reg2); end
    @(posedge clk);
    #1 bus.instr = 8'hC0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({bus.rf_reg_write, bus.done, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 1'b1, 2'd1, 8'hFF}) begin
      n_fail++; $display("FAIL chg_write: got wen=%b done=%b reg=%0d data=%h want 1 1 1 ff",
                         bus.rf_reg_write, bus.done, bus.rf_write_reg, bus.rf_write_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic wen, dn, ov; logic [1:0] wreg; logic [7:0] wdata;
    preload(2'd1, 8'h11);
    preload(2'd2, 8'h00);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = 8'h16;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.instr_ready, bus.rf_reg_write, bus.done, bus.rf_read_reg1, bus.rf_write_reg, bus.rf_write_data} !== 13'd0) begin
      n_fail++; $display("FAIL midrst_async: got ready=%b wen=%b done=%b rd1=%0d wreg=%0d wdata=%h want all 0",
                         bus.instr_ready, bus.rf_reg_write, bus.done, bus.rf_read_reg1, bus.rf_write_reg, bus.rf_write_data); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({bus.rf_reg_write, bus.done} !== 2'b00) begin
        n_fail++; $display("FAIL midrst_no_write[%0d]: got wen=%b done=%b want 0 0", i, bus.rf_reg_write, bus.done); end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", bus.instr_ready); end
    n_checks++; if (rf[2] !== 8'h00) begin n_fail++; $display("FAIL midrst_r2_untouched: got %h want 00", rf[2]); end
    run_instr(8'h16, wen, wreg, wdata, dn, ov);
    n_checks++; if ({wen, dn, wreg, wdata} !== {1'b1, 1'b1, 2'd2, 8'h22}) begin
      n_fail++; $display("FAIL midrst_resume: got wen=%b done=%b reg=%0d data=%h want 1 1 2 22", wen, dn, wreg, wdata); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    load_en = 1'b0;
    load_addr = 2'd0;
    load_data = 8'h00;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    test_reset();
    test_arith();
    test_ovf();
    test_back_to_back();
    test_instr_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Multi-cycle sequencer that executes 8-bit instructions against the 4-entry × 8-bit register file, driving its two read ports and single write port. It sits between the instruction source (valid/ready handshake) and the register file, and owns the fetch/read/execute/write-back ordering. One instruction completes every 4 cycles. No read-after-write hazard is possible.

## Interface
- DATA_W, 8, register/operand width
- ADDR_W, 2, register address width (4 registers)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction available
- instr_ready  out  1  controller can accept an instruction
- instr  in  8  instruction word; fields op[7:6], rs[5:4], rt[3:2], rd[1:0] (imm = [1:0])
- rf_read_reg1  out  ADDR_W  register file read address 1
- rf_read_reg2  out  ADDR_W  register file read address 2
- rf_read_data1  in  DATA_W  combinational read data 1
- rf_read_data2  in  DATA_W  combinational read data 2
- rf_write_reg  out  ADDR_W  write address
- rf_write_data  out  DATA_W  write data
- rf_reg_write  out  1  write enable, one cycle per writing instruction
- done  out  1  one-cycle pulse at write-back of every instruction (including NOP)
- ovf  out  1  signed-overflow flag (see Configuration)

## Operation
- States: IDLE, READ, EXEC, WB. Reset state IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, capture instr into ir, go READ. Otherwise stay.
- READ: rf_read_reg1=ir.rs, rf_read_reg2=ir.rt. At end of cycle, latch rf_read_data1/2 into opA/opB. Go EXEC.
- EXEC: compute result from opA/opB and ir.op into res register. Go WB.
- WB: rf_write_reg/rf_write_data driven from registered dest/res. rf_reg_write=1 unless NOP. done=1. Go IDLE.
- Opcodes:
  - 00 ADD: rd = rs + rt
  - 01 ADDI: rt = rs + sext(imm[1:0]), range −2..+1
  - 10 SUB: rd = rs − rt
  - 11 NOP: no write
- Arithmetic is modulo 2^DATA_W. Carry/borrow is discarded.
- Read addresses hold their last value outside READ.
- All outputs are registered or decoded from registered state only. There is no combinational path from instr inputs to outputs.
- Reset values: instr_ready=0 during reset (1 in IDLE after release); rf_reg_write=0, done=0, ovf=0. All address/data outputs=0. ir, opA, opB, res=0.
- Reset mid-operation: abort immediately. The in-flight instruction is discarded and no write is issued. Resume in IDLE after release.
- instr is sampled only on the handshake edge. Changes at other times are ignored.
- instr_valid held high: next acceptance occurs on the edge ending the IDLE cycle after WB.

## Timing
- Handshake on edge E0. READ = cycle 1, EXEC = cycle 2, WB = cycle 3.
- rf_reg_write and done are high during cycle 3. The register file captures on edge E3. instr_ready returns high in cycle 4.
- Throughput: 1 instruction / 4 cycles.
- Latency from acceptance to written value visible on rf_read_data: 3 edges.

## Configuration
- REGFILE_CTRL_OVF_EN defined:
  - ovf is a register updated on the WB edge of ADD/ADDI/SUB with the signed 2's-complement overflow of that operation.
  - ovf holds through NOP and IDLE.
- Not defined:
  - ovf tied to 0 and the overflow logic is absent.
  - The port remains, so the interface is unchanged.

## Structure
- Package regfile_ctrl_pkg holds:
  - opcode enum (OP_ADD, OP_ADDI, OP_SUB, OP_NOP)
  - state enum (ST_IDLE, ST_READ, ST_EXEC, ST_WB)
  - instruction field bit positions
- Sub-module regfile_ctrl_alu (combinational):
  - inputs opA, opB, sext-imm, op
  - outputs result and overflow
  - instantiated once, feeding res in EXEC.
- FSM, instruction register and handshake stay in regfile_ctrl.

## Test plan
- All registers 0. Send ADDI 0x47 (r1=r0+(−1)) → cycle 3 after handshake: rf_reg_write=1, rf_write_reg=1, rf_write_data=0xFF, done=1.
- Then ADD 0x16 (r2=r1+r1) → write r2=0xFE. Then SUB 0x87 (r3=r0−r1) → write r3=0x01.
- Model holds r1=0x7F, r2=0x01. ADD 0x1B (r3=r1+r2) → write 0x80, ovf=1 with REGFILE_CTRL_OVF_EN, ovf=0 without. A following NOP 0xC0 → done=1, rf_reg_write=0, ovf unchanged.
- instr_valid held high with 0x47 for 12 cycles → exactly 3 acceptances, at edges 0, 4 and 8. instr_ready low in every non-IDLE cycle.
- Assert rst_n low during EXEC of ADD 0x16 → outputs 0 asynchronously, no rf_reg_write pulse. After release, instr_ready=1 on the first cycle and the next instruction executes normally.
- Change instr during READ/EXEC after handshake of 0x47 → written value still 0xFF to r1.
